// File: rtl/conv_accum_save_if.sv
// Bus between the conv stage and the accumulate/save block: pixel strobe,
// channel bookkeeping, save acknowledge, plane status and readout port.
interface conv_accum_save_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16
);
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic [7:0]            pix_addr;
    logic                  conv_done;
    logic [3:0]            chan;
    logic [3:0]            last_chan;
    logic                  layer;
    logic                  save_done;
    logic                  plane_ready;
    logic                  overrun;
    logic                  rd_en;
    logic [7:0]            rd_addr;
    logic [ACC_WIDTH-1:0]  rd_data;

    modport master (
        output pix_valid, pix_data, pix_addr, conv_done, chan, last_chan, layer,
        output rd_en, rd_addr,
        input  save_done, plane_ready, overrun, rd_data
    );

    modport slave (
        input  pix_valid, pix_data, pix_addr, conv_done, chan, last_chan, layer,
        input  rd_en, rd_addr,
        output save_done, plane_ready, overrun, rd_data
    );
endinterface

// File: rtl/conv_accum_save.sv
// Accumulates conv output pixels across input channels into a word memory.
// Define CONV_ACCUM_SAT_EN to saturate accumulation instead of wrapping.
module conv_accum_save #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic            clk,
    input  logic            rst,
    conv_accum_save_if.slave bus
);
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_e;

    state_e                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        data_q, data_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [CHAN_W-1:0]            chan_q, chan_d;
    logic                         layer_q, layer_d;
    logic                         done_q, done_d;
    logic signed [ACC_WIDTH-1:0]  rdv_q, rdv_d;
    logic [ACC_WIDTH-1:0]         rd_data_q, rd_data_d;
    logic                         save_done_q, save_done_d;
    logic                         plane_ready_q, plane_ready_d;
    logic                         overrun_q, overrun_d;

    logic signed [ACC_WIDTH-1:0]  mem_q [DEPTH];
    logic signed [ACC_WIDTH-1:0]  ext_c, sum_c;
    logic                         accept_c, mem_we_c;

    assign accept_c = (state_q == IDLE) && bus.pix_valid;

    // Pixel widening: conv1 pixels are unsigned, conv2 pixels are two's complement
    always_comb begin
        ext_c = ACC_WIDTH'(data_q);
        if (layer_q) ext_c = ACC_WIDTH'(signed'(data_q));
    end

`ifdef CONV_ACCUM_SAT_EN
    logic signed [ACC_WIDTH:0] wide_c;

    always_comb begin
        wide_c = (ACC_WIDTH+1)'(rdv_q) + (ACC_WIDTH+1)'(ext_c);
        sum_c  = wide_c[ACC_WIDTH-1:0];
        if (chan_q == '0)
            sum_c = ext_c;
        else if (wide_c[ACC_WIDTH] != wide_c[ACC_WIDTH-1])
            sum_c = wide_c[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    always_comb begin
        sum_c = (chan_q == '0) ? ext_c : rdv_q + ext_c;
    end
`endif

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        addr_d        = addr_q;
        chan_d        = chan_q;
        layer_d       = layer_q;
        done_d        = done_q;
        rdv_d         = rdv_q;
        rd_data_d     = rd_data_q;
        save_done_d   = 1'b0;
        plane_ready_d = plane_ready_q;
        overrun_d     = overrun_q;

        if (bus.pix_valid && (state_q != IDLE)) overrun_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.rd_en) rd_data_d = mem_q[MEM_AW'(bus.rd_addr)];
                if (bus.pix_valid) begin
                    data_d  = bus.pix_data;
                    addr_d  = bus.pix_addr;
                    chan_d  = bus.chan;
                    layer_d = bus.layer;
                    done_d  = bus.conv_done;
                    state_d = READ;
                    if (bus.chan == '0) plane_ready_d = 1'b0;
                end else if (bus.conv_done) begin
                    // Stand-alone channel end is evaluated and consumed on the spot
                    chan_d = bus.chan;
                    done_d = 1'b0;
                    if (bus.chan == bus.last_chan) plane_ready_d = 1'b1;
                end
            end
            READ: begin
                rdv_d   = mem_q[MEM_AW'(addr_q)];
                state_d = WRITE;
            end
            WRITE: begin
                save_done_d = 1'b1;
                state_d     = ACK;
            end
            ACK: begin
                if (done_q && (chan_q == bus.last_chan)) plane_ready_d = 1'b1;
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= '0;
            addr_q        <= '0;
            chan_q        <= '0;
            layer_q       <= 1'b0;
            done_q        <= 1'b0;
            rdv_q         <= '0;
            rd_data_q     <= '0;
            save_done_q   <= 1'b0;
            plane_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
            chan_q        <= chan_d;
            layer_q       <= layer_d;
            done_q        <= done_d;
            rdv_q         <= rdv_d;
            rd_data_q     <= rd_data_d;
            save_done_q   <= save_done_d;
            plane_ready_q <= plane_ready_d;
            overrun_q     <= overrun_d;
        end
    end

    // Accumulator storage is deliberately left out of reset
    assign mem_we_c = (state_q == WRITE) && !rst && (32'(addr_q) < DEPTH);

    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[MEM_AW'(addr_q)] <= sum_c;
    end

    assign bus.save_done   = save_done_q;
    assign bus.overrun     = overrun_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.plane_ready = plane_ready_q && !(accept_c && (bus.chan == '0));
endmodule

// File: tb/tb_conv_accum_save.sv
// Directed bench for conv_accum_save: latency, accumulation, overrun,
// plane status, readout behaviour and mid-operation reset.
module tb_conv_accum_save;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   sd_count;
    logic [15:0] sat_exp;

    conv_accum_save_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) bus ();

    conv_accum_save #(.DATA_WIDTH(8), .ACC_WIDTH(16), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pix(input logic [7:0] d, input logic [7:0] a, input logic [3:0] c,
                             input logic l, input logic cd);
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_addr  = a;
        bus.chan      = c;
        bus.layer     = l;
        bus.conv_done = cd;
    endtask

    task automatic do_pixel(input logic [7:0] d, input logic [7:0] a, input logic [3:0] c,
                            input logic l);
        drive_pix(d, a, c, l, 1'b0);
        tick();
        bus.pix_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic read_word(input logic [7:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sd_count = 0;
`ifdef CONV_ACCUM_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h803B;
`endif
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_addr  = '0;
        bus.conv_done = 1'b0;
        bus.chan      = '0;
        bus.last_chan = 4'd1;
        bus.layer     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        tick();
        tick();
        check("rst_save_done",   32'(bus.save_done),   32'd0);
        check("rst_plane_ready", 32'(bus.plane_ready), 32'd0);
        check("rst_overrun",     32'(bus.overrun),     32'd0);
        check("rst_rd_data",     32'(bus.rd_data),     32'd0);
        rst = 1'b0;
        tick();

        // conv1 pixel 0xC8, channel 0, addr 5: ack exactly three cycles later
        drive_pix(8'hC8, 8'd5, 4'd0, 1'b0, 1'b0);
        tick();
        bus.pix_valid = 1'b0;
        check("lat_c1", 32'(bus.save_done), 32'd0);
        tick();
        check("lat_c2", 32'(bus.save_done), 32'd0);
        tick();
        check("lat_c3", 32'(bus.save_done), 32'd1);
        tick();
        check("lat_c4", 32'(bus.save_done), 32'd0);
        read_word(8'd5);
        check("rd_c8", 32'(bus.rd_data), 32'd200);
        tick();
        check("rd_hold", 32'(bus.rd_data), 32'd200);

        // conv2 pixel -5 on last channel with coincident conv_done
        drive_pix(8'hFB, 8'd5, 4'd1, 1'b1, 1'b1);
        tick();
        bus.pix_valid = 1'b0;
        bus.conv_done = 1'b0;
        tick();
        tick();
        check("pr_in_ack", 32'(bus.plane_ready), 32'd0);
        tick();
        check("pr_after_ack", 32'(bus.plane_ready), 32'd1);
        read_word(8'd5);
        check("rd_195", 32'(bus.rd_data), 32'd195);

        // Back-to-back pixel is dropped; busy readout is ignored
        drive_pix(8'd10, 8'd5, 4'd1, 1'b0, 1'b0);
        tick();
        bus.pix_data = 8'd99;
        tick();
        bus.pix_valid = 1'b0;
        check("overrun_set", 32'(bus.overrun), 32'd1);
        if (bus.save_done) sd_count++;
        tick();
        if (bus.save_done) sd_count++;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'd5;
        tick();
        bus.rd_en = 1'b0;
        if (bus.save_done) sd_count++;
        check("rd_busy_hold", 32'(bus.rd_data), 32'd195);
        repeat (3) begin
            tick();
            if (bus.save_done) sd_count++;
        end
        check("one_save_done", 32'(sd_count), 32'd1);
        read_word(8'd5);
        check("rd_205", 32'(bus.rd_data), 32'd205);
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        check("pr_still_high", 32'(bus.plane_ready), 32'd1);

        // New plane: channel-0 pixel clears plane_ready in its own cycle and overwrites
        drive_pix(8'd7, 8'd5, 4'd0, 1'b0, 1'b0);
        #1;
        check("pr_clear_same", 32'(bus.plane_ready), 32'd0);
        tick();
        bus.pix_valid = 1'b0;
        check("pr_clear_after", 32'(bus.plane_ready), 32'd0);
        repeat (3) tick();
        read_word(8'd5);
        check("rd_overwrite", 32'(bus.rd_data), 32'd7);

        // Build 32700 = 60 + 128*255, then add 127
        do_pixel(8'd60, 8'd9, 4'd0, 1'b0);
        for (int i = 0; i < 128; i++) do_pixel(8'd255, 8'd9, 4'd1, 1'b0);
        read_word(8'd9);
        check("rd_32700", 32'(bus.rd_data), 32'd32700);
        do_pixel(8'd127, 8'd9, 4'd1, 1'b0);
        read_word(8'd9);
        check("rd_limit", 32'(bus.rd_data), 32'(sat_exp));

        // Stand-alone conv_done: below last channel no effect, on last channel sets ready
        bus.conv_done = 1'b1;
        bus.chan      = 4'd0;
        tick();
        bus.conv_done = 1'b0;
        check("cd_not_last", 32'(bus.plane_ready), 32'd0);
        bus.conv_done = 1'b1;
        bus.chan      = 4'd1;
        tick();
        bus.conv_done = 1'b0;
        check("cd_last", 32'(bus.plane_ready), 32'd1);

        // Reset while in WRITE aborts the save
        drive_pix(8'd50, 8'd9, 4'd1, 1'b0, 1'b0);
        tick();
        bus.pix_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_save_done",   32'(bus.save_done),   32'd0);
        check("abort_plane_ready", 32'(bus.plane_ready), 32'd0);
        check("abort_overrun",     32'(bus.overrun),     32'd0);
        check("abort_rd_data",     32'(bus.rd_data),     32'd0);
        rst = 1'b0;
        tick();
        check("abort_no_ack", 32'(bus.save_done), 32'd0);
        read_word(8'd9);
        check("abort_mem_kept", 32'(bus.rd_data), 32'(sat_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_accum_save.md
CONV_ACCUM_SAVE -- requirements
Module: conv_accum_save

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the incoming conv pixel.
- REQ-002 SHALL have parameter ACC_WIDTH, default 16, width of the signed accumulator word.
- REQ-003 SHALL have parameter DEPTH, default 256, number of accumulator entries (covers a 14x13 = 182 output plane).
- REQ-004 clk  input  1  sole clock, all logic on posedge.
- REQ-005 rst  input  1  reset, synchronous, active-high.
- REQ-006 pix_valid  input  1  single-cycle strobe from the conv stage: out_pixel is valid.
- REQ-007 pix_data  input  DATA_WIDTH  conv output pixel.
- REQ-008 pix_addr  input  8  pixel index within the output plane.
- REQ-009 conv_done  input  1  single-cycle pulse from the conv stage: channel finished; may coincide with the last pix_valid.
- REQ-010 chan  input  4  current input channel, 0..last_chan.
- REQ-011 last_chan  input  4  index of the final input channel.
- REQ-012 layer  input  1  0 = conv1 (pixel unsigned), 1 = conv2 (pixel signed two's complement).
- REQ-013 save_done  output  1  single-cycle acknowledge to the conv stage: pixel stored.
- REQ-014 plane_ready  output  1  accumulation over all channels is complete.
- REQ-015 overrun  output  1  sticky error: pixel arrived while busy.
- REQ-016 rd_en  input  1  readout request.
- REQ-017 rd_addr  input  8  readout index.
- REQ-018 rd_data  output  ACC_WIDTH  readout word, signed.

Function
- REQ-019 SHALL implement states IDLE, READ, WRITE, ACK.
- REQ-020 Transitions SHALL be:
  - IDLE to READ on pix_valid.
  - READ to WRITE unconditionally.
  - WRITE to ACK unconditionally.
  - ACK to IDLE unconditionally.
- REQ-021 In IDLE on pix_valid, SHALL capture pix_data, pix_addr, chan, layer, and conv_done into internal registers.
- REQ-022 READ SHALL fetch mem[addr]; WRITE SHALL store the result.
- REQ-023 The stored result SHALL be the extended pixel when the captured chan==0, otherwise mem[addr] plus the extended pixel.
- REQ-024 Pixel extension SHALL be zero-extension to ACC_WIDTH when layer==0 and sign-extension when layer==1.
- REQ-025 save_done SHALL be high for exactly one cycle while in ACK, i.e. 3 cycles after the pix_valid sample cycle.
- REQ-026 pix_valid outside IDLE SHALL be dropped, SHALL set overrun, and SHALL NOT alter memory or state.
- REQ-027 conv_done sampled in IDLE without pix_valid SHALL be latched the same way.
- REQ-028 plane_ready SHALL rise in the cycle after ACK (or after the IDLE sample, for REQ-027) when the latched conv_done is set and the captured chan==last_chan.
- REQ-029 conv_done with a chan below last_chan SHALL only clear the latch.
- REQ-030 plane_ready SHALL stay high until a pix_valid with chan==0 is accepted, and SHALL clear in that same cycle.
- REQ-031 A pix_addr at or above DEPTH SHALL be ignored for the write, and save_done SHALL still be issued.
- REQ-032 Readout SHALL have 1-cycle latency: rd_en at cycle t gives rd_data = mem[rd_addr] at t+1.
- REQ-033 rd_data SHALL hold its value when rd_en is low.
- REQ-034 rd_en while not in IDLE SHALL be ignored, and rd_data SHALL hold.

Reset
- REQ-035 On rst, the state SHALL be IDLE and save_done, plane_ready, overrun, rd_data, and all capture registers SHALL be 0.
- REQ-036 rst mid-operation SHALL abort with no save_done and no write in that cycle.
- REQ-037 Memory contents need not be cleared by rst.

Configuration
- REQ-038 Macro CONV_ACCUM_SAT_EN defined: accumulation SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- REQ-039 Macro CONV_ACCUM_SAT_EN undefined: accumulation SHALL wrap modulo 2^ACC_WIDTH.

Verification
- REQ-040 layer=0, chan=0, pixel 0xC8 at addr 5 -> save_done exactly 3 cycles later; rd addr 5 -> 200.
- REQ-041 layer=1, chan=1 (last_chan=1), pixel 0xFB at addr 5 after REQ-040 -> 195; conv_done coincident with that pix_valid -> plane_ready high the cycle after ACK.
- REQ-042 pix_valid one cycle after an accepted pix_valid -> overrun=1, one save_done only, memory unchanged.
- REQ-043 Accumulate +127 into a word holding 32700 -> 32767 with CONV_ACCUM_SAT_EN; -32709 without it.
- REQ-044 rst asserted in WRITE -> no save_done; mem unchanged; all outputs 0 the next cycle.
- REQ-045 plane_ready high, then pix_valid chan=0 -> plane_ready 0 that cycle; new plane overwrites old values.
